// File: rtl/fp16_int16_converter.sv
// Bidirectional converter between signed 16-bit integers and IEEE-754 half
// precision. Alignment/normalisation is done one bit per cycle in SHIFT, the
// result is rounded (int->fp) or negated (fp->int) in PACK and held in DONE
// until the consumer takes it.
module fp16_int16_converter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [15:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] r,
  output logic        negative,
  output logic        zero,
  output logic        overflow,
  output logic        inexact,
  output logic        nan
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PACK  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Leading-zero count of a 16-bit value; 16 when the value is zero.
  function automatic logic [4:0] lead_zeros(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) n = 5'(15 - i);
    end
    return n;
  endfunction

  // Control and working registers.
  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic        sign_q, sign_d;       // fp sign (int->fp) or negate-in-PACK (fp->int)
  logic        left_q, left_d;       // shift direction during SHIFT
  logic [15:0] sh_q, sh_d;           // value being aligned
  logic [3:0]  cnt_q, cnt_d;         // remaining SHIFT cycles
  logic [4:0]  exp_q, exp_d;         // biased exponent for int->fp
  logic        sticky_q, sticky_d;   // ones lost by right shifts (fp->int)
  logic        ovf_q, ovf_d;
  logic        nan_q, nan_d;

  // Result registers, updated only in PACK.
  logic [15:0] r_q, r_d;
  logic        neg_q, neg_d;
  logic        zero_q, zero_d;
  logic        ovfo_q, ovfo_d;
  logic        inex_q, inex_d;
  logic        nano_q, nano_d;

  // Operand decode used at the accepting edge.
  logic [15:0] mag;
  logic [4:0]  lz;
  logic [4:0]  fe;
  logic [9:0]  fm;
  logic [3:0]  rsh;
  logic [3:0]  lsh;

  assign mag = x[15] ? (~x + 16'd1) : x;   // -32768 wraps to 0x8000 as unsigned
  assign lz  = lead_zeros(mag);
  assign fe  = x[14:10];
  assign fm  = x[9:0];
  assign rsh = 4'(5'd25 - fe);
  assign lsh = 4'(fe - 5'd25);

  logic [15:0] acc_sh;
  logic [3:0]  acc_cnt;
  logic [4:0]  acc_exp;
  logic        acc_sign;
  logic        acc_left;
  logic        acc_sticky;
  logic        acc_ovf;
  logic        acc_nan;

  // Work out the initial datapath load and shift count for a new operand.
  // Special fp inputs are loaded as the final integer with no negation, so
  // PACK treats every fp->int case the same way.
  always_comb begin
    acc_sh     = 16'h0000;
    acc_cnt    = 4'd0;
    acc_exp    = 5'd0;
    acc_sign   = 1'b0;
    acc_left   = 1'b1;
    acc_sticky = 1'b0;
    acc_ovf    = 1'b0;
    acc_nan    = 1'b0;
    if (!mode) begin
      acc_sign = x[15];
      acc_sh   = mag;
      if (mag != 16'h0000) begin
        acc_cnt = lz[3:0];
        acc_exp = 5'd30 - lz;
      end
    end else begin
      if (fe == 5'd31) begin
        if (fm != 10'd0) begin
          acc_sh  = 16'h8000;
          acc_nan = 1'b1;
        end else begin
          acc_sh  = x[15] ? 16'h8000 : 16'h7FFF;
          acc_ovf = 1'b1;
        end
      end else if (fe < 5'd15) begin
        acc_sticky = |x[14:0];
      end else if (fe >= 5'd30) begin
        // -32768.0 is the only representable value in this range
        acc_sh  = x[15] ? 16'h8000 : 16'h7FFF;
        acc_ovf = (x != 16'hF800);
      end else begin
        acc_sh   = {5'b00000, 1'b1, fm};
        acc_sign = x[15];
        if (fe < 5'd25) begin
          acc_left = 1'b0;
          acc_cnt  = rsh;
        end else begin
          acc_cnt  = lsh;
        end
      end
    end
  end

  // PACK-stage result: round-to-nearest-even for int->fp, negate for fp->int.
  logic [9:0]  pk_mant;
  logic        pk_guard;
  logic        pk_st;
  logic        pk_inc;
  logic [14:0] pk_mag;
  logic [15:0] pk_r;
  logic        pk_inexact;
  logic        pk_ovf;
  logic        pk_nan;
  logic        pk_zero;

  // Compute the value and flags that PACK will register.
  always_comb begin
    pk_mant    = sh_q[14:5];
    pk_guard   = sh_q[4];
    pk_st      = |sh_q[3:0];
    pk_inc     = pk_guard & (pk_st | pk_mant[0]);
    pk_mag     = {exp_q, pk_mant} + {14'd0, pk_inc};  // mantissa carry bumps exponent
    pk_r       = {sign_q, pk_mag};
    pk_inexact = pk_guard | pk_st;
    pk_ovf     = 1'b0;
    pk_nan     = 1'b0;
    pk_zero    = (pk_mag == 15'd0);
    if (mode_q) begin
      pk_r       = sign_q ? (~sh_q + 16'd1) : sh_q;
      pk_inexact = sticky_q;
      pk_ovf     = ovf_q;
      pk_nan     = nan_q;
      pk_zero    = (pk_r == 16'h0000);
    end
  end

  // Next-state and datapath update for the IDLE/SHIFT/PACK/DONE sequence.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sign_d   = sign_q;
    left_d   = left_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    nan_d    = nan_q;
    r_d      = r_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    ovfo_d   = ovfo_q;
    inex_d   = inex_q;
    nano_d   = nano_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d   = mode;
          sign_d   = acc_sign;
          left_d   = acc_left;
          sh_d     = acc_sh;
          cnt_d    = acc_cnt;
          exp_d    = acc_exp;
          sticky_d = acc_sticky;
          ovf_d    = acc_ovf;
          nan_d    = acc_nan;
          state_d  = (acc_cnt == 4'd0) ? PACK : SHIFT;
        end
      end
      SHIFT: begin
        if (left_q) begin
          sh_d = {sh_q[14:0], 1'b0};
        end else begin
          sh_d     = {1'b0, sh_q[15:1]};
          sticky_d = sticky_q | sh_q[0];
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = PACK;
      end
      PACK: begin
        r_d     = pk_r;
        neg_d   = pk_r[15];
        zero_d  = pk_zero;
        ovfo_d  = pk_ovf;
        inex_d  = pk_inexact;
        nano_d  = pk_nan;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      sign_q   <= 1'b0;
      left_q   <= 1'b1;
      sh_q     <= 16'h0000;
      cnt_q    <= 4'd0;
      exp_q    <= 5'd0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      nan_q    <= 1'b0;
      r_q      <= 16'h0000;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovfo_q   <= 1'b0;
      inex_q   <= 1'b0;
      nano_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      sign_q   <= sign_d;
      left_q   <= left_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      nan_q    <= nan_d;
      r_q      <= r_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      ovfo_q   <= ovfo_d;
      inex_q   <= inex_d;
      nano_q   <= nano_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign r         = r_q;
  assign negative  = neg_q;
  assign zero      = zero_q;
  assign overflow  = ovfo_q;
  assign inexact   = inex_q;
  assign nan       = nano_q;

endmodule

// File: tb/tb_fp16_int16_converter.sv
// Self-checking bench for fp16_int16_converter: arithmetic reference model,
// pinned literal cases, per-cycle compare of handshake, latency and results.
module tb_fp16_int16_converter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [15:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] r;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        inexact;
  logic        nan;

  fp16_int16_converter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .x(x), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .negative(negative), .zero(zero), .overflow(overflow),
    .inexact(inexact), .nan(nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] r;
    logic [4:0]  fl;   // {negative, zero, overflow, inexact, nan}
    int          lat;  // edges from accepting edge (inclusive) to out_valid
    int          acc;  // value of cyc just after the accepting edge
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model computed from the numeric definition of each conversion.
  function automatic exp_t model(input logic m, input logic [15:0] v);
    exp_t   e;
    longint a, qq, rem, half, sig, mg, val;
    int     k, sh, ex;
    logic   sgn, ine, ovf, nn;
    e.acc = 0; e.r = 16'h0000; e.lat = 2;
    ine = 1'b0; ovf = 1'b0; nn = 1'b0;
    if (!m) begin
      val = longint'($signed(v));
      sgn = (val < 0);
      a   = sgn ? -val : val;
      if (a != 0) begin
        k = 0;
        while ((64'sd1 <<< (k + 1)) <= a) k++;
        e.lat = 15 - k + 2;
        if (k <= 10) begin
          qq = a <<< (10 - k);
        end else begin
          sh   = k - 10;
          qq   = a >>> sh;
          rem  = a - (qq <<< sh);
          half = 64'sd1 <<< (sh - 1);
          if (rem > half || (rem == half && qq[0])) qq++;
          if (qq == 2048) begin qq = 1024; k++; end
          ine = (rem != 0);
        end
        e.r = {sgn, 5'(k + 15), 10'(qq - 1024)};
      end
    end else begin
      ex = int'(v[14:10]);
      if (ex == 31) begin
        if (v[9:0] != 10'd0) begin e.r = 16'h8000; nn = 1'b1; end
        else begin e.r = v[15] ? 16'h8000 : 16'h7FFF; ovf = 1'b1; end
      end else begin
        sig = (ex == 0) ? longint'(v[9:0]) : 1024 + longint'(v[9:0]);
        if (ex == 0) ex = 1;
        if (ex >= 25) mg = sig <<< (ex - 25);
        else begin
          mg  = sig >>> (25 - ex);
          ine = ((mg <<< (25 - ex)) != sig);
        end
        val = v[15] ? -mg : mg;
        if (val > 32767) begin e.r = 16'h7FFF; ovf = 1'b1; end
        else if (val < -32768) begin e.r = 16'h8000; ovf = 1'b1; end
        else e.r = 16'(val);
        if (ex >= 15 && ex <= 29) e.lat = ((ex >= 25) ? ex - 25 : 25 - ex) + 2;
      end
    end
    e.fl = {e.r[15], (m ? (e.r == 16'h0000) : (e.r[14:0] == 15'd0)), ovf, ine, nn};
    return e;
  endfunction

  // {mode, x, r, flags, latency} taken from hand-worked cases
  localparam int NLIT = 16;
  logic [42:0] lits [NLIT] = '{
    {1'b0, 16'h0001, 16'h3C00, 5'b00000, 5'd17},
    {1'b0, 16'hFFFB, 16'hC500, 5'b10000, 5'd15},
    {1'b0, 16'h0000, 16'h0000, 5'b01000, 5'd2},
    {1'b0, 16'h0801, 16'h6800, 5'b00010, 5'd6},
    {1'b0, 16'h0803, 16'h6802, 5'b00010, 5'd6},
    {1'b0, 16'h7FFF, 16'h7800, 5'b00010, 5'd3},
    {1'b0, 16'h8000, 16'hF800, 5'b10000, 5'd2},
    {1'b1, 16'h4D00, 16'h0014, 5'b00000, 5'd8},
    {1'b1, 16'hC500, 16'hFFFB, 5'b10000, 5'd10},
    {1'b1, 16'h3C01, 16'h0001, 5'b00010, 5'd12},
    {1'b1, 16'h3800, 16'h0000, 5'b01010, 5'd2},
    {1'b1, 16'h7800, 16'h7FFF, 5'b00100, 5'd2},
    {1'b1, 16'hF800, 16'h8000, 5'b10000, 5'd2},
    {1'b1, 16'h7C00, 16'h7FFF, 5'b00100, 5'd2},
    {1'b1, 16'hFC00, 16'h8000, 5'b10100, 5'd2},
    {1'b1, 16'h7E00, 16'h8000, 5'b10001, 5'd2}
  };

  logic        mon_inflight;
  logic        mon_ov;
  logic [4:0]  dut_fl;
  logic [42:0] lit;
  exp_t        pe;
  logic        rnd_m;
  logic [15:0] rnd_v;

  assign dut_fl = {negative, zero, overflow, inexact, nan};

  // One conversion: present operand, optionally poke in_valid while busy,
  // hold out_ready low for 'hold' cycles in DONE, then take the result.
  task automatic run_op(input logic m, input logic [15:0] v, input int hold, input int poke);
    exp_t e;
    int   w;
    e     = model(m, v);
    e.acc = cyc + 1;
    q.push_back(e);
    $display("op mode=%0d x=%h expect r=%h fl=%b lat=%0d", m, v, e.r, e.fl, e.lat);
    mode = m; x = v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      if (poke != 0) begin in_valid = 1'b1; mode = 1'($urandom); x = 16'($urandom); end
      @(posedge clk); #1;
      w++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      bad++;
      $display("FAIL timeout: out_valid=%b required 1 within 40 cycles", out_valid);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q.delete();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      if (poke != 0) begin in_valid = 1'b1; mode = 1'($urandom); x = 16'($urandom); end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; x = 16'h0000; out_ready = 1'b0;

    // Per-cycle compare: handshake, latency and result against the model.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          mon_inflight = 1'b0;
          mon_ov       = 1'b0;
          if (q.size() > 0) begin
            mon_inflight = (cyc >= q[0].acc);
            mon_ov = mon_inflight && ((cyc - q[0].acc + 1) >= q[0].lat);
          end
          total++;
          if (in_ready !== !mon_inflight) begin
            bad++;
            $display("FAIL in_ready: got %b required %b (cyc %0d)", in_ready, !mon_inflight, cyc);
          end
          total++;
          if (out_valid !== mon_ov) begin
            bad++;
            $display("FAIL out_valid: got %b required %b (cyc %0d)", out_valid, mon_ov, cyc);
          end
          if (mon_ov && out_valid) begin
            total++;
            if (r !== q[0].r || dut_fl !== q[0].fl) begin
              bad++;
              $display("FAIL result: got r=%h fl=%b required r=%h fl=%b", r, dut_fl, q[0].r, q[0].fl);
            end
            if (out_ready) q.pop_front();
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, r, dut_fl} !== {1'b1, 1'b0, 16'h0000, 5'b00000}) begin
      bad++;
      $display("FAIL reset: got rdy=%b vld=%b r=%h fl=%b required 1 0 0000 00000",
               in_ready, out_valid, r, dut_fl);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Literal cases pin the model, then go through the DUT.
    for (int i = 0; i < NLIT; i++) begin
      lit = lits[i];
      pe  = model(lit[42], lit[41:26]);
      total++;
      if (pe.r !== lit[25:10] || pe.fl !== lit[9:5] || pe.lat != int'(lit[4:0])) begin
        bad++;
        $display("FAIL model_pin x=%h: got r=%h fl=%b lat=%0d required r=%h fl=%b lat=%0d",
                 lit[41:26], pe.r, pe.fl, pe.lat, lit[25:10], lit[9:5], lit[4:0]);
      end
      run_op(lit[42], lit[41:26], (i == 0) ? 5 : i % 3, i % 2);
    end

    // Reset during SHIFT discards the operation.
    pe     = model(1'b0, 16'h0001);
    pe.acc = cyc + 1;
    q.push_back(pe);
    mode = 1'b0; x = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    total++;
    if ({in_ready, out_valid, r, dut_fl} !== {1'b1, 1'b0, 16'h0000, 5'b00000}) begin
      bad++;
      $display("FAIL mid_reset: got rdy=%b vld=%b r=%h fl=%b required 1 0 0000 00000",
               in_ready, out_valid, r, dut_fl);
    end
    run_op(1'b0, 16'h0803, 0, 0);

    // Randomised conversions, biased toward in-range fp exponents.
    for (int i = 0; i < 300; i++) begin
      rnd_m = 1'($urandom_range(0, 1));
      rnd_v = 16'($urandom);
      if (rnd_m && $urandom_range(0, 1) == 1) rnd_v[14:10] = 5'($urandom_range(15, 29));
      run_op(rnd_m, rnd_v, $urandom_range(0, 3), $urandom_range(0, 1));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
